// File: rtl/car_pkg.sv
// Shared definitions for every stage of the car pipeline.
//   car_state_t : encoding of the car's top-level operating state
//   CLK_FREQ    : default system clock frequency in Hz
package car_pkg;

    typedef enum logic [1:0] {
        POWER_OFF    = 2'b00,
        NOT_STARTING = 2'b01,
        STARTING     = 2'b10,
        MOVING       = 2'b11
    } car_state_t;

    localparam int unsigned CLK_FREQ = 100_000_000;

endpackage

// File: rtl/odometer_pkg.sv
// Odometer-local constants and helpers.
//   BCD_MAX          : largest legal BCD digit value
//   prescaler_width  : counter width needed to count 0..ticks-1 (at least 1 bit)
package odometer_pkg;

    localparam logic [3:0] BCD_MAX = 4'd9;

    function automatic int unsigned prescaler_width(input int unsigned ticks);
        return (ticks > 1) ? $clog2(ticks) : 1;
    endfunction

endpackage

// File: rtl/odometer_if.sv
// Motion inputs and distance outputs of the odometer stage.
//   state, move_forward, move_backward, clear : driven by the car / user side
//   mileage (packed BCD, digit 0 in [3:0]), unit_tick, moving : driven by the odometer
// master = the side driving motion/clear, slave = the odometer itself.
interface odometer_if
    import car_pkg::*;
#(
    parameter int unsigned DIGITS = 8
);

    car_state_t              state;
    logic                    move_forward;
    logic                    move_backward;
    logic                    clear;
    logic [4*DIGITS-1:0]     mileage;
    logic                    unit_tick;
    logic                    moving;

    modport master (
        output state, move_forward, move_backward, clear,
        input  mileage, unit_tick, moving
    );

    modport slave (
        input  state, move_forward, move_backward, clear,
        output mileage, unit_tick, moving
    );

endinterface

// File: rtl/odometer_bcd_digit.sv
// One decimal digit of the mileage counter.
//   clk, rst_n : clock, asynchronous active-low reset
//   inc        : advance this digit by one (wraps 9 -> 0)
//   clr        : synchronous clear, wins over inc
//   q          : current digit value, always 0..9
//   carry      : inc while at 9, i.e. the next digit must advance
module bcd_digit
    import odometer_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic       inc,
    input  logic       clr,
    output logic [3:0] q,
    output logic       carry
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q <= '0;
        end else if (clr) begin
            q <= '0;
        end else if (inc) begin
            q <= (q >= BCD_MAX) ? 4'd0 : q + 4'd1;
        end
    end

    assign carry = inc & (q == BCD_MAX);

endmodule

// File: rtl/odometer.sv
// Distance accumulator for the car.
//   clk, rst_n : clock, asynchronous active-low reset
//   bus        : odometer_if.slave
//                in : state, move_forward, move_backward, clear
//                out: mileage (packed BCD), unit_tick (pulse per unit), moving
// Distance advances one unit per UNIT_TICKS cycles spent MOVING with exactly one
// direction requested; a partial unit survives stops. Power-off or clear zeroes it.
module odometer
    import car_pkg::*;
    import odometer_pkg::*;
#(
    parameter int unsigned UNIT_TICKS = 100_000_000,
    parameter int unsigned DIGITS     = 8
)
(
    input  logic       clk,
    input  logic       rst_n,
    odometer_if.slave  bus
);

    localparam int unsigned   PW   = prescaler_width(UNIT_TICKS);
    localparam logic [PW-1:0] LAST = PW'(UNIT_TICKS - 1);

    logic                qual;
    logic                clear_cond;
    logic                wrap;
    logic [PW-1:0]       prescaler;
    logic                unit_tick_q;
    logic                moving_q;
    logic [DIGITS:0]     carry_chain;
    logic [4*DIGITS-1:0] mileage_q;
    logic                unused_wrap_carry;

    always_comb begin
        qual       = (bus.state == MOVING) & (bus.move_forward ^ bus.move_backward);
        clear_cond = (bus.state == POWER_OFF) | bus.clear;
        wrap       = qual & (prescaler == LAST);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prescaler <= '0;
        end else if (clear_cond) begin
            prescaler <= '0;
        end else if (qual) begin
            prescaler <= (prescaler == LAST) ? '0 : prescaler + PW'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            unit_tick_q <= 1'b0;
            moving_q    <= 1'b0;
        end else begin
            unit_tick_q <= wrap & ~clear_cond;
            moving_q    <= qual;
        end
    end

    // Ripple of increment enables: digit i advances only when all lower digits carry.
    assign carry_chain[0] = wrap;

    for (genvar i = 0; i < DIGITS; i++) begin : g_digit
        bcd_digit u_digit (
            .clk   (clk),
            .rst_n (rst_n),
            .inc   (carry_chain[i]),
            .clr   (clear_cond),
            .q     (mileage_q[4*i +: 4]),
            .carry (carry_chain[i+1])
        );
    end

    // Full wrap of the top digit is silent (no overflow flag).
    assign unused_wrap_carry = carry_chain[DIGITS];

    assign bus.mileage   = mileage_q;
    assign bus.unit_tick = unit_tick_q;
    assign bus.moving    = moving_q;

endmodule
